// File: rtl/tt_div_pkg.sv
// Shared constants, state encoding and pin bit positions for the sequential byte divider.
package tt_div_pkg;

  localparam int DIV_W = 8;
  localparam int CNT_W = 3;

  localparam logic [DIV_W-1:0] DBZ_QUOTIENT = 8'hFF;
  localparam logic [7:0]       UIO_OE_MASK  = 8'hF0;
  localparam logic [CNT_W-1:0] CNT_LAST     = 3'd7;

  // uio_in strobe / select positions
  localparam int LOAD_A_BIT = 0;
  localparam int START_BIT  = 1;
  localparam int SEL_BIT    = 2;

  // uio_out status positions
  localparam int BUSY_BIT = 4;
  localparam int DONE_BIT = 5;
  localparam int DBZ_BIT  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tt_div_step.sv
// One combinational restoring-division iteration: shift {rem, q} left by one
// and conditionally subtract the divisor from the widened partial remainder.
module tt_div_step
  import tt_div_pkg::*;
(
  input  logic [DIV_W-1:0] i_rem,
  input  logic [DIV_W-1:0] i_q,
  input  logic [DIV_W-1:0] i_div,
  output logic [DIV_W-1:0] o_rem,
  output logic [DIV_W-1:0] o_q
);

  logic [DIV_W:0] w_shift;

  // Compare in 9 bits so a divisor above 127 never overflows the shifted remainder;
  // the difference always fits back into 8 bits because it is below the divisor.
  always_comb begin
    w_shift = {i_rem, i_q[DIV_W-1]};
    o_rem   = w_shift[DIV_W-1:0];
    o_q     = {i_q[DIV_W-2:0], 1'b0};
    if (w_shift >= {1'b0, i_div}) begin
      o_rem = w_shift[DIV_W-1:0] - i_div;
      o_q   = {i_q[DIV_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/tt_um_matthewelse_div.sv
// Sequential unsigned 8-bit divider on the Tiny Tapeout pinout.
// Operands are captured on strobe rising edges from uio_in, one quotient bit
// is produced per cycle, and quotient/remainder are muxed onto uo_out by sel.
// Optional macro DIV_SYNC_EN inserts a 2-flop synchronizer on the strobes.
module tt_um_matthewelse_div
  import tt_div_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t           r_state;
  logic [1:0]       r_prev;
  logic [DIV_W-1:0] r_a;
  logic [DIV_W-1:0] r_b;
  logic [DIV_W-1:0] r_rem;
  logic [DIV_W-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_quo;
  logic [DIV_W-1:0] r_rmd;
  logic             r_dbz;

  logic [1:0]       w_strb;
  logic [1:0]       w_edge;
  logic [DIV_W-1:0] w_dividend;
  logic [DIV_W-1:0] w_nrem;
  logic [DIV_W-1:0] w_nq;
  logic             w_unused;

  assign w_unused = &{1'b0, uio_in[7:3]};

`ifdef DIV_SYNC_EN
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;

  // Two-stage synchronizer for asynchronous strobes before edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else if (ena) begin
      r_sync1 <= uio_in[START_BIT:LOAD_A_BIT];
      r_sync2 <= r_sync1;
    end
  end

  assign w_strb = r_sync2;
`else
  assign w_strb = uio_in[START_BIT:LOAD_A_BIT];
`endif

  assign w_edge = w_strb & ~r_prev;

  // A simultaneous load_a edge supplies the dividend to the starting operation.
  assign w_dividend = w_edge[LOAD_A_BIT] ? ui_in : r_a;

  tt_div_step u_step (
    .i_rem (r_rem),
    .i_q   (r_q),
    .i_div (r_b),
    .o_rem (w_nrem),
    .o_q   (w_nq)
  );

  // Control FSM, operand capture, iteration registers and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_prev  <= 2'b00;
      r_a     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rmd   <= '0;
      r_dbz   <= 1'b0;
    end else if (ena) begin
      r_prev <= w_strb;
      case (r_state)
        RUN: begin
          r_rem <= w_nrem;
          r_q   <= w_nq;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == CNT_LAST) begin
            r_state <= DONE;
            r_quo   <= w_nq;
            r_rmd   <= w_nrem;
          end
        end
        default: begin
          if (w_edge[LOAD_A_BIT]) begin
            r_a <= ui_in;
          end
          if (w_edge[START_BIT]) begin
            if (ui_in == '0) begin
              r_state <= DONE;
              r_quo   <= DBZ_QUOTIENT;
              r_rmd   <= w_dividend;
              r_dbz   <= 1'b1;
            end else begin
              r_state <= RUN;
              r_b     <= ui_in;
              r_rem   <= '0;
              r_q     <= w_dividend;
              r_cnt   <= '0;
              r_dbz   <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  // Result select and status pin mapping.
  always_comb begin
    uo_out            = uio_in[SEL_BIT] ? r_rmd : r_quo;
    uio_out           = 8'h00;
    uio_out[BUSY_BIT] = (r_state == RUN);
    uio_out[DONE_BIT] = (r_state == DONE);
    uio_out[DBZ_BIT]  = r_dbz;
    uio_oe            = UIO_OE_MASK;
  end

endmodule

// File: doc/tt_um_matthewelse_div.md
# tt_um_matthewelse_div

Sequential unsigned 8-bit divider on the standard Tiny Tapeout pinout. It is the inverse-arithmetic counterpart of the team's combinational byte adder: operands arrive on `ui_in` under strobes on `uio_in`, and quotient or remainder is read back on `uo_out`. A restoring shift-subtract core takes one quotient bit per cycle. Status handshake bits are driven on the upper half of the bidirectional bus.

## Interface
- No parameters. Width is fixed at 8 by the pinout.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ena` input 1: when 0, every register holds its value and strobes are not sampled.
- `ui_in` input 8: operand byte.
- `uio_in` input 8:
  - [0] `load_a`: rising edge captures the dividend.
  - [1] `start`: rising edge captures the divisor and begins the operation.
  - [2] `sel`: 0 shows the quotient, 1 shows the remainder.
  - [7:3] are ignored.
- `uo_out` output 8: result byte selected by `sel`.
- `uio_out` output 8:
  - [3:0] = 0.
  - [4] `busy`.
  - [5] `done`.
  - [6] `dbz`, the divide-by-zero flag.
  - [7] = 0.
- `uio_oe` output 8: constant 8'hF0, including during reset.

## Operation
- Strobe edge detection: registered previous value of `uio_in[1:0]`. An edge means current=1 and previous=0, sampled at a clock edge with `ena`=1.
- `load_a` edge in IDLE or DONE: `ui_in` is written to the dividend register. It is ignored in RUN.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE to RUN, on a `start` edge with a nonzero divisor:
  - `ui_in` goes to the divisor register.
  - The partial remainder is set to 0 and the shift register is loaded with the dividend.
  - The iteration count is set to 0.
  - `done` and `dbz` clear.
- IDLE/DONE to DONE, on a `start` edge with divisor = 0:
  - quotient result = 8'hFF.
  - remainder result = dividend.
  - `dbz`=1.
- Each RUN cycle performs one restoring step (9-bit compare/subtract):
  - Shift {rem, q} left by one, bringing the dividend MSB into the remainder.
  - If rem ≥ divisor: rem −= divisor and the q LSB becomes 1.
  - Otherwise the q LSB becomes 0.
  - Remainder arithmetic is 9 bits wide, so there is no overflow for divisor > 127.
- RUN to DONE after the 8th step. The quotient and remainder result registers are written on that same edge.
- Strobes in RUN are ignored, including a `start` edge.
- A `load_a` edge and a `start` edge on the same cycle: the dividend is taken from `ui_in` for both operands. `load_a` wins the write, and start then uses the new dividend.
- Result registers change only on entry to DONE. Intermediate values never appear on `uo_out`.
- `uo_out` is a combinational mux of the result registers by `sel`. It has no latency relative to `sel`.
- Outputs are status decodes of the registered FSM state:
  - `busy` = (state==RUN).
  - `done` = (state==DONE).

## Timing
- Reset, asynchronous, takes effect immediately:
  - state IDLE.
  - All data, result and edge registers are 0.
  - `uo_out`=0.
  - `uio_out`=0.
- Normal operation, with the `start` edge captured at clock edge E0:
  - `busy`=1 after E0.
  - Steps run on E1..E8.
  - After E8: `busy`=0, `done`=1, results valid.
  - Total: 8 cycles from capture to `done`.
- Divide by zero: `done`=1 and `dbz`=1 directly after E0.
- Back-to-back operation: a new `start` edge is accepted in the first DONE cycle.
- `rst_n` low mid-RUN aborts the operation. Results return to 0.
- `ena`=0 mid-RUN freezes the step counter. The operation resumes with identical results.

## Configuration
- `DIV_SYNC_EN` defined:
  - Adds a 2-flop synchronizer on `uio_in[1:0]` ahead of edge detection.
  - The flops reset to 0.
  - Strobe-to-capture latency grows by 2 cycles.
  - `ui_in` must be held stable for those cycles.
- `DIV_SYNC_EN` undefined: strobes feed the edge detector directly, and capture happens on the first edge where the strobe is seen high.

## Structure
- Package `tt_div_pkg`:
  - State enum (IDLE, RUN, DONE).
  - `DIV_W` = 8.
  - Step-count width = 3.
  - `DBZ_QUOTIENT` = 8'hFF.
  - `UIO_OE_MASK` = 8'hF0.
  - Bit-index constants for load_a, start, sel, busy, done and dbz.
- Sub-module `tt_div_step`: a combinational single restoring iteration.
  - Inputs: rem, q, divisor.
  - Outputs: next rem, next q.
  - The top holds the FSM, the registers and the pin mapping.

## Test plan
- Load 200, start 7 → `done` after 8 cycles. `sel`=0 gives `uo_out`=28, `sel`=1 gives 4, `dbz`=0.
- Load 255, start 1 → q=255, r=0. Then load 9, start 255 (divisor > 127) → q=0, r=9.
- Load 5, start 0 → `done`=1 and `dbz`=1 one cycle after the start edge, q=8'hFF, r=5.
- Start 3 with dividend 100, then pulse `start` with `ui_in`=1 and `load_a` in cycle 4 of RUN → both ignored; result q=33, r=1.
- Start 13 with dividend 250, assert `rst_n`=0 at step 5 → all outputs 0 immediately, `uio_oe`=F0; after release a fresh 250/13 gives q=19, r=3.
- Drop `ena` for 5 cycles mid-RUN on 77/6 → `busy` holds; `done` arrives 5 cycles later than normal; q=12, r=5.
